regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the next-generation pipelined core. It replaces the fixed 32x32, 2-read/1-write file.
- Configurable width, depth, read-port count and write-port count.
- Optional same-cycle write-to-read bypass.
- Built-in per-register busy scoreboard: decode allocates a destination, writeback clears it; hazard logic reads the busy bits.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of two, >=2)
NRD, 2, number of read ports
NWR, 2, number of write ports
BYPASS, 1, 1 = read ports forward same-cycle write data; 0 = reads see only stored state
ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy
(local) AW = $clog2(NREGS)

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
rd_addr_i  input  NRD x AW  read addresses
rd_data_o  output  NRD x XLEN  read data, combinational
rd_busy_o  output  NRD x 1  busy status of each read address, combinational
wr_en_i  input  NWR x 1  write enables
wr_addr_i  input  NWR x AW  write addresses
wr_data_i  input  NWR x XLEN  write data
alloc_en_i  input  1  mark alloc_addr_i busy (destination issued)
alloc_addr_i  input  AW  register to mark busy
flush_i  input  1  clear all busy bits (pipeline flush)
busy_o  output  NREGS  full scoreboard vector, registered

Behaviour:
Reset:
- reset_n low clears all registers to 0 and all busy bits to 0, immediately and asynchronously.
- During reset, rd_data_o = 0, rd_busy_o = 0 and busy_o = 0.
- Reset asserted mid-write discards the write.

Writes:
- Each port with wr_en_i=1 updates its register at the rising edge; one-cycle write latency.
- Several ports targeting the same address in one cycle: the highest-index port wins.
- ZERO_REG=1: writes to address 0 are dropped and register 0 always reads 0.
- wr_en_i=0: no state change.

Reads:
- Purely combinational from the addresses.
- BYPASS=1: if any enabled write port targets rd_addr_i[k] this cycle (and it is not x0 with ZERO_REG=1), rd_data_o[k] = that port's wr_data_i, highest-index matching port first. Otherwise rd_data_o[k] = stored value.
- BYPASS=0: stored value only; new data is visible the cycle after the write.

Scoreboard:
- busy[r] next-state priority, highest first:
  1. flush_i=1 -> 0 for every r; any alloc in the same cycle is ignored.
  2. alloc_en_i=1 and alloc_addr_i==r -> 1. Alloc beats a simultaneous writeback to r, because a new producer supersedes the old one.
  3. Any enabled write port with wr_addr_i==r -> 0.
  4. Otherwise hold.
- Flush never alters register data.
- ZERO_REG=1: alloc to address 0 is ignored and busy[0] is constantly 0.
- rd_busy_o[k] = busy[rd_addr_i[k]], forced to 0 when BYPASS=1 and an enabled write to that address occurs this cycle. Data is then available via the bypass.
- busy_o exposes the registered busy vector without bypass masking.

Widths:
- No arithmetic beyond address compare.
- Addresses are exactly AW bits; there are no out-of-range addresses.

Decomposition:
- Package regfile_pkg:
  - default constants XLEN_DEF, NREGS_DEF.
  - typedefs reg_addr_t (logic [AW-1:0]) and xlen_t (logic [XLEN-1:0]).
  - Parameterised forms are expressed as localparams inside the module, since package typedefs cannot follow module parameters.
- Sub-module regfile_scoreboard:
  - Owns the busy vector, alloc/flush/clear priority and x0 masking.
  - Ports: clk, reset_n, alloc, flush, write-clear vector, busy_o.
- regfile_mp instantiates it and holds the storage array plus the read/bypass mux.

Test Plan:
1. Reset, then write 0xDEADBEEF to r5 on port 0; read r5 on both ports the next cycle -> 0xDEADBEEF. Write 0x1234 to r0 -> r0 reads 0.
2. Same cycle: port 0 writes r7=0x11, port 1 writes r7=0x22 -> r7 = 0x22 afterwards. With BYPASS=1, a same-cycle read of r7 -> 0x22.
3. BYPASS=0: write r3=0xA5 and read r3 in the same cycle -> old value 0. Next cycle -> 0xA5.
4. Alloc r9 -> busy_o[9]=1 next cycle. Write r9 with alloc r9 in the same cycle -> busy stays 1. A later write-only cycle on r9 -> busy 0. Alloc r0 -> busy_o[0] stays 0.
5. Alloc r4, r6 in consecutive cycles, then assert flush_i together with alloc r8 -> busy_o all 0 and register contents unchanged.
6. Write r10=0x55 and r11=0x66, then pulse reset_n low mid-cycle with a pending write to r10 -> all outputs 0 immediately. After release, r10, r11 and busy_o all read 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and types for the multi-port register file
package regfile_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  // Default-size types; parameterised widths live as localparams in each module.
  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xlen_t;
endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - read/write/scoreboard bus of the multi-port register file
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD-1:0][AW-1:0]   rd_addr_i;
  logic [NRD-1:0][XLEN-1:0] rd_data_o;
  logic [NRD-1:0]           rd_busy_o;
  logic [NWR-1:0]           wr_en_i;
  logic [NWR-1:0][AW-1:0]   wr_addr_i;
  logic [NWR-1:0][XLEN-1:0] wr_data_i;
  logic                     alloc_en_i;
  logic [AW-1:0]            alloc_addr_i;
  logic                     flush_i;
  logic [NREGS-1:0]         busy_o;

  modport master (
    output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, alloc_en_i, alloc_addr_i, flush_i,
    input  rd_data_o, rd_busy_o, busy_o
  );

  modport slave (
    input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, alloc_en_i, alloc_addr_i, flush_i,
    output rd_data_o, rd_busy_o, busy_o
  );
endinterface

// File: rtl/regfile_mp_scoreboard.sv
// rtl/regfile_mp_scoreboard.sv - per-register busy bits: flush > alloc > writeback clear
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = NREGS_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     alloc_en,
  input  logic [$clog2(NREGS)-1:0] alloc_addr,
  input  logic                     flush,
  input  logic [NREGS-1:0]         clr,
  output logic [NREGS-1:0]         busy_o
);
  localparam int AW = $clog2(NREGS);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        // A fresh producer supersedes the one whose writeback lands this cycle.
        if (alloc_en && alloc_addr == AW'(r))
          busy_d[r] = 1'b1;
        else if (clr[r])
          busy_d[r] = 1'b0;
      end
    end
    if (ZERO_REG != 0)
      busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  assign busy_o = busy_q;
endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised NRD-read/NWR-write register file with bypass and busy scoreboard
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input logic          clk,
  input logic          reset_n,
  regfile_mp_if.slave  bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]          mem [NREGS];
  logic [NREGS-1:0]         clr;
  logic [NREGS-1:0]         busy;
  logic [NRD-1:0][XLEN-1:0] rd_data;
  logic [NRD-1:0]           rd_busy;

  // Later ports overwrite earlier ones, so the highest-index port wins a collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++)
        mem[i] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (bus.wr_en_i[p] && !(ZERO_REG != 0 && bus.wr_addr_i[p] == '0))
          mem[bus.wr_addr_i[p]] <= bus.wr_data_i[p];
      end
    end
  end

  always_comb begin
    clr = '0;
    for (int p = 0; p < NWR; p++) begin
      if (bus.wr_en_i[p])
        clr[bus.wr_addr_i[p]] = 1'b1;
    end
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .reset_n    (reset_n),
    .alloc_en   (bus.alloc_en_i),
    .alloc_addr (bus.alloc_addr_i),
    .flush      (bus.flush_i),
    .clr        (clr),
    .busy_o     (busy)
  );

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      rd_data[k] = mem[bus.rd_addr_i[k]];
      rd_busy[k] = busy[bus.rd_addr_i[k]];
      if (BYPASS != 0) begin
        for (int p = 0; p < NWR; p++) begin
          if (bus.wr_en_i[p] && bus.wr_addr_i[p] == bus.rd_addr_i[k]) begin
            rd_data[k] = bus.wr_data_i[p];
            rd_busy[k] = 1'b0;
          end
        end
      end
      if (ZERO_REG != 0 && bus.rd_addr_i[k] == '0) begin
        rd_data[k] = '0;
        rd_busy[k] = 1'b0;
      end
      // Mask the bypass path too, so reads are quiet while reset is held.
      if (!reset_n) begin
        rd_data[k] = '0;
        rd_busy[k] = 1'b0;
      end
    end
  end

  assign bus.rd_data_o = rd_data;
  assign bus.rd_busy_o = rd_busy;
  assign bus.busy_o    = busy;
endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp (bypass and non-bypass builds)
module tb_regfile_mp;
  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) b1 ();
  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) b0 ();

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1))
    dut_byp (.clk(clk), .reset_n(reset_n), .bus(b1));
  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(0), .ZERO_REG(1))
    dut_nob (.clk(clk), .reset_n(reset_n), .bus(b0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    b1.wr_en_i = '0; b1.wr_addr_i = '0; b1.wr_data_i = '0;
    b1.alloc_en_i = 1'b0; b1.alloc_addr_i = '0; b1.flush_i = 1'b0;
    b0.wr_en_i = '0; b0.wr_addr_i = '0; b0.wr_data_i = '0;
    b0.alloc_en_i = 1'b0; b0.alloc_addr_i = '0; b0.flush_i = 1'b0;
  endtask

  // Advance past one rising edge and settle on the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    idle();
    b1.rd_addr_i = '0;
    b0.rd_addr_i = '0;
    #12;
    chk("reset_rd0", b1.rd_data_o[0], 32'h0);
    chk("reset_busy", b1.busy_o, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;

    // 1: basic write, read on both ports; writes to x0 are dropped
    b1.wr_en_i[0] = 1'b1; b1.wr_addr_i[0] = 5'd5; b1.wr_data_i[0] = 32'hDEADBEEF;
    b1.rd_addr_i[0] = 5'd5; b1.rd_addr_i[1] = 5'd5;
    #1;
    chk("bypass_r5", b1.rd_data_o[0], 32'hDEADBEEF);
    step();
    idle();
    #1;
    chk("r5_port0", b1.rd_data_o[0], 32'hDEADBEEF);
    chk("r5_port1", b1.rd_data_o[1], 32'hDEADBEEF);
    b1.wr_en_i[0] = 1'b1; b1.wr_addr_i[0] = 5'd0; b1.wr_data_i[0] = 32'h1234;
    b1.rd_addr_i[0] = 5'd0;
    #1;
    chk("x0_bypass", b1.rd_data_o[0], 32'h0);
    step();
    idle();
    #1;
    chk("x0_stored", b1.rd_data_o[0], 32'h0);

    // 2: two ports hit r7, port 1 wins both bypass and storage
    b1.wr_en_i = 2'b11;
    b1.wr_addr_i[0] = 5'd7; b1.wr_data_i[0] = 32'h11;
    b1.wr_addr_i[1] = 5'd7; b1.wr_data_i[1] = 32'h22;
    b1.rd_addr_i[0] = 5'd7;
    #1;
    chk("r7_bypass_prio", b1.rd_data_o[0], 32'h22);
    step();
    idle();
    #1;
    chk("r7_stored_prio", b1.rd_data_o[0], 32'h22);

    // 3: no bypass, new data appears a cycle later
    b0.wr_en_i[0] = 1'b1; b0.wr_addr_i[0] = 5'd3; b0.wr_data_i[0] = 32'hA5;
    b0.rd_addr_i[0] = 5'd3;
    #1;
    chk("nobyp_same_cycle", b0.rd_data_o[0], 32'h0);
    step();
    idle();
    #1;
    chk("nobyp_next_cycle", b0.rd_data_o[0], 32'hA5);

    // 4: alloc/writeback interplay on r9; alloc to x0 ignored
    b1.alloc_en_i = 1'b1; b1.alloc_addr_i = 5'd9;
    b1.rd_addr_i[0] = 5'd9;
    step();
    idle();
    #1;
    chk("alloc_r9", b1.busy_o, 32'h0000_0200);
    chk("rd_busy_r9", {31'h0, b1.rd_busy_o[0]}, 32'h1);
    b1.alloc_en_i = 1'b1; b1.alloc_addr_i = 5'd9;
    b1.wr_en_i[0] = 1'b1; b1.wr_addr_i[0] = 5'd9; b1.wr_data_i[0] = 32'h99;
    #1;
    chk("rd_busy_masked", {31'h0, b1.rd_busy_o[0]}, 32'h0);
    step();
    idle();
    #1;
    chk("alloc_beats_wb", b1.busy_o, 32'h0000_0200);
    b1.wr_en_i[1] = 1'b1; b1.wr_addr_i[1] = 5'd9; b1.wr_data_i[1] = 32'h9A;
    step();
    idle();
    #1;
    chk("wb_clears_r9", b1.busy_o, 32'h0);
    b1.alloc_en_i = 1'b1; b1.alloc_addr_i = 5'd0;
    step();
    idle();
    #1;
    chk("alloc_x0_ignored", b1.busy_o, 32'h0);

    // 5: flush beats same-cycle alloc and leaves data alone
    b1.alloc_en_i = 1'b1; b1.alloc_addr_i = 5'd4;
    step();
    b1.alloc_addr_i = 5'd6;
    step();
    idle();
    #1;
    chk("alloc_r4_r6", b1.busy_o, 32'h0000_0050);
    b1.flush_i = 1'b1; b1.alloc_en_i = 1'b1; b1.alloc_addr_i = 5'd8;
    step();
    idle();
    b1.rd_addr_i[0] = 5'd5; b1.rd_addr_i[1] = 5'd7;
    #1;
    chk("flush_busy", b1.busy_o, 32'h0);
    chk("flush_keep_r5", b1.rd_data_o[0], 32'hDEADBEEF);
    chk("flush_keep_r7", b1.rd_data_o[1], 32'h22);

    // 6: asynchronous reset in the middle of a pending write
    b1.wr_en_i = 2'b11;
    b1.wr_addr_i[0] = 5'd10; b1.wr_data_i[0] = 32'h55;
    b1.wr_addr_i[1] = 5'd11; b1.wr_data_i[1] = 32'h66;
    b1.alloc_en_i = 1'b1; b1.alloc_addr_i = 5'd12;
    step();
    idle();
    b1.rd_addr_i[0] = 5'd10; b1.rd_addr_i[1] = 5'd11;
    #1;
    chk("r10_written", b1.rd_data_o[0], 32'h55);
    chk("r11_written", b1.rd_data_o[1], 32'h66);
    chk("busy_r12", b1.busy_o, 32'h0000_1000);
    b1.wr_en_i[0] = 1'b1; b1.wr_addr_i[0] = 5'd10; b1.wr_data_i[0] = 32'hCAFE;
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_rd0", b1.rd_data_o[0], 32'h0);
    chk("rst_rd1", b1.rd_data_o[1], 32'h0);
    chk("rst_busy", b1.busy_o, 32'h0);
    step();
    idle();
    reset_n = 1'b1;
    #1;
    chk("post_rst_r10", b1.rd_data_o[0], 32'h0);
    chk("post_rst_r11", b1.rd_data_o[1], 32'h0);
    chk("post_rst_busy", b1.busy_o, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
